if_stage: RTL and testbench

//  Instruction-fetch stage of the in-order pipeline. It produces if_id_stage_reg for the ID stage.
//  - Owns the PC and the order counter.
//  - Issues word reads to instruction memory and predecodes the returned word.
//  - Honours downstream stall and EX-stage redirects (taken branch/jump).

---
 rtl/if_stage.sv | 161 ++++++++++++++++
 tb/tb_if_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns PC and order count, fetches one word per request,
// predecodes it and presents a registered packet to ID with stall/redirect handling.
package if_stage_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] order;
    logic [6:0]  opcode;
    logic [4:0]  rd_s;
    logic [2:0]  funct3;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [6:0]  funct7;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
  } if_id_stage_reg_t;
endpackage

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  output logic [3:0]       imem_rmask,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_resp,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output if_id_stage_reg_t if_id_stage_reg,
  output logic             if_id_valid
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [63:0]      order_q, order_d;
  logic [31:0]      hold_q, hold_d;
  if_id_stage_reg_t pkt_q, pkt_d;
  logic             vld_q, vld_d;

  logic             accept;
  logic             deliver;
  logic [31:0]      word;

  function automatic if_id_stage_reg_t predecode(input logic [31:0] inst,
                                                 input logic [31:0] pc,
                                                 input logic [63:0] order);
    if_id_stage_reg_t p;
    p.inst   = inst;
    p.pc     = pc;
    p.order  = order;
    p.opcode = inst[6:0];
    p.rd_s   = inst[11:7];
    p.funct3 = inst[14:12];
    p.rs1_s  = inst[19:15];
    p.rs2_s  = inst[24:20];
    p.funct7 = inst[31:25];
    p.i_imm  = {{20{inst[31]}}, inst[31:20]};
    p.s_imm  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    p.b_imm  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    p.u_imm  = {inst[31:12], 12'h000};
    p.j_imm  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    return p;
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    order_d = order_q;
    hold_d  = hold_q;
    pkt_d   = pkt_q;
    vld_d   = vld_q;
    deliver = 1'b0;
    word    = imem_rdata;
    accept  = !vld_q || !stall;

    unique case (state_q)
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        if (imem_resp) begin
          if (accept) begin
            deliver = 1'b1;
          end else begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (accept) begin
          deliver = 1'b1;
          word    = hold_q;
        end
      end
      S_DRAIN: if (imem_resp) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    if (deliver) begin
      pc_d    = pc_q + 32'd4;
      state_d = S_REQ;
    end

    if (!(vld_q && stall)) begin
      if (deliver) begin
        pkt_d   = predecode(word, pc_q, order_q);
        vld_d   = 1'b1;
        order_d = order_q + 64'd1;
      end else begin
        vld_d = 1'b0;
      end
    end

    // A redirect discards everything in flight; an unanswered request must still be drained.
    if (redirect) begin
      pc_d    = redirect_pc & ~32'h3;
      vld_d   = 1'b0;
      hold_d  = '0;
      pkt_d   = pkt_q;
      order_d = order_q;
      state_d = ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_resp) ? S_DRAIN : S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      order_q <= '0;
      hold_q  <= '0;
      pkt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      order_q <= order_d;
      hold_q  <= hold_d;
      pkt_q   <= pkt_d;
      vld_q   <= vld_d;
    end
  end

  assign imem_addr       = {pc_q[31:2], 2'b00};
  assign imem_rmask      = (state_q == S_REQ && !rst) ? 4'hF : 4'h0;
  assign if_id_stage_reg = pkt_q;
  assign if_id_valid     = vld_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run against a
// packet-stream reference model (expected PC/order sequence and arithmetic predecode).
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h6000_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      imem_addr;
  logic [3:0]       imem_rmask;
  logic [31:0]      imem_rdata = '0;
  logic             imem_resp = 1'b0;
  logic             stall = 1'b0;
  logic             redirect = 1'b0;
  logic [31:0]      redirect_pc = '0;
  if_id_stage_reg_t pkt;
  logic             vld;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_stage_reg(pkt), .if_id_valid(vld)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          lat = 1;
  logic [31:0] salt = 32'h0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_addr = '0;
  logic [31:0] ovr_data = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr_en && a == ovr_addr) return ovr_data;
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic if_id_stage_reg_t ref_pkt(input logic [31:0] w, input logic [31:0] pc,
                                               input logic [63:0] ord);
    if_id_stage_reg_t p;
    logic [31:0] sx;
    sx = w[31] ? 32'hFFFF_FFFF : 32'h0;
    p.inst   = w;
    p.pc     = pc;
    p.order  = ord;
    p.opcode = 7'(w & 32'h7F);
    p.rd_s   = 5'((w >> 7) & 32'h1F);
    p.funct3 = 3'((w >> 12) & 32'h7);
    p.rs1_s  = 5'((w >> 15) & 32'h1F);
    p.rs2_s  = 5'((w >> 20) & 32'h1F);
    p.funct7 = 7'(w >> 25);
    p.i_imm  = (sx << 12) | (w >> 20);
    p.s_imm  = (sx << 12) | ((w >> 20) & 32'hFE0) | ((w >> 7) & 32'h1F);
    p.b_imm  = (sx << 12) | ((w << 4) & 32'h800) | ((w >> 20) & 32'h7E0) | ((w >> 7) & 32'h1E);
    p.u_imm  = w & 32'hFFFF_F000;
    p.j_imm  = (sx << 20) | (w & 32'h000F_F000) | ((w >> 9) & 32'h800) | ((w >> 20) & 32'h7FE);
    return p;
  endfunction

  // Instruction memory: one outstanding request, answered lat cycles later; reset forgets it.
  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    int          cnt;
    pend = 1'b0;
    pend_addr = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      imem_resp  = 1'b0;
      imem_rdata = $urandom;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt <= 0) begin
            imem_resp  = 1'b1;
            imem_rdata = mem_word(pend_addr);
            pend       = 1'b0;
          end
        end
        if (imem_rmask == 4'hF) begin
          pend      = 1'b1;
          pend_addr = imem_addr;
          cnt       = lat;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    total++; if (imem_rmask !== 4'h0) begin bad++; $display("FAIL rst_rmask got=%h want=0", imem_rmask); end
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", vld); end
    total++; if (pkt !== '0) begin bad++; $display("FAIL rst_pkt got pc=%h ord=%0d inst=%h want all zero", pkt.pc, pkt.order, pkt.inst); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (imem_rmask !== 4'hF) begin bad++; $display("FAIL rst_first_req got=%h want=f", imem_rmask); end
    total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL rst_first_addr got=%h want=%h", imem_addr, RST_PC); end
  endtask

  task automatic test_sequential();
    if_id_stage_reg_t e;
    logic [31:0] epc;
    do_reset();
    lat = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (vld !== (i == 2 || i == 4 || i == 6)) begin
        bad++; $display("FAIL seq_valid cyc=%0d got=%b", i, vld);
      end
      if (i == 2 || i == 4 || i == 6) begin
        epc = RST_PC + 32'(4 * (i / 2 - 1));
        e = ref_pkt(mem_word(epc), epc, 64'(i / 2 - 1));
        total++;
        if (pkt !== e) begin
          bad++; $display("FAIL seq_pkt got pc=%h ord=%0d inst=%h want pc=%h ord=%0d inst=%h",
                          pkt.pc, pkt.order, pkt.inst, e.pc, e.order, e.inst);
        end
      end
    end
  endtask

  task automatic test_decode();
    int n;
    ovr_en = 1'b1; ovr_addr = RST_PC; ovr_data = 32'hFE01_0EE3;
    lat = 1;
    do_reset();
    n = 0;
    do begin @(negedge clk); n++; end while (vld !== 1'b1 && n < 10);
    total++;
    if (vld !== 1'b1) begin
      bad++; $display("FAIL dec_timeout got valid=%b want=1", vld);
    end else begin
      total++; if (pkt.b_imm !== 32'hFFFF_FFFC) begin bad++; $display("FAIL dec_bimm got=%h want=fffffffc", pkt.b_imm); end
      total++; if (pkt.rs1_s !== 5'd2) begin bad++; $display("FAIL dec_rs1 got=%0d want=2", pkt.rs1_s); end
      total++; if (pkt.rs2_s !== 5'd0) begin bad++; $display("FAIL dec_rs2 got=%0d want=0", pkt.rs2_s); end
      // bits [14:12] of this encoding are 000
      total++; if (pkt.funct3 !== 3'd0) begin bad++; $display("FAIL dec_funct3 got=%0d want=0", pkt.funct3); end
      total++; if (pkt.opcode !== 7'h63) begin bad++; $display("FAIL dec_opcode got=%h want=63", pkt.opcode); end
      total++;
      if (pkt !== ref_pkt(32'hFE01_0EE3, RST_PC, 64'd0)) begin
        bad++; $display("FAIL dec_pkt got i=%h s=%h u=%h j=%h rd=%0d f7=%h", pkt.i_imm, pkt.s_imm,
                        pkt.u_imm, pkt.j_imm, pkt.rd_s, pkt.funct7);
      end
    end
    ovr_en = 1'b0;
  endtask

  task automatic test_stall();
    if_id_stage_reg_t e0, e1;
    e0 = ref_pkt(mem_word(RST_PC), RST_PC, 64'd0);
    e1 = ref_pkt(mem_word(RST_PC + 32'd4), RST_PC + 32'd4, 64'd1);
    do_reset();
    lat = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stall = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      total++;
      if (vld !== 1'b1 || pkt !== e0) begin
        bad++; $display("FAIL stall_hold cyc=%0d got v=%b pc=%h ord=%0d want v=1 pc=%h ord=0",
                        i, vld, pkt.pc, pkt.order, e0.pc);
      end
      if (i > 2) begin
        total++; if (imem_rmask !== 4'h0) begin bad++; $display("FAIL stall_rmask cyc=%0d got=%h want=0", i, imem_rmask); end
      end
    end
    @(posedge clk); #1;
    stall = 1'b0;
    @(negedge clk);
    total++; if (vld !== 1'b1 || pkt !== e0) begin bad++; $display("FAIL stall_rel0 got v=%b pc=%h want v=1 pc=%h", vld, pkt.pc, e0.pc); end
    total++; if (imem_rmask !== 4'h0) begin bad++; $display("FAIL stall_rel0_rmask got=%h want=0", imem_rmask); end
    @(negedge clk);
    total++;
    if (vld !== 1'b1 || pkt !== e1) begin
      bad++; $display("FAIL stall_rel1 got v=%b pc=%h ord=%0d inst=%h want v=1 pc=%h ord=1 inst=%h",
                      vld, pkt.pc, pkt.order, pkt.inst, e1.pc, e1.inst);
    end
    total++; if (imem_rmask !== 4'hF || imem_addr !== RST_PC + 32'd8) begin bad++; $display("FAIL stall_next_req got rmask=%h addr=%h want f/%h", imem_rmask, imem_addr, RST_PC + 32'd8); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    lat = 3;
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h6000_0100;
    @(posedge clk); #1;
    redirect = 1'b0; lat = 1;
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk);
      total++;
      if (imem_rmask !== 4'h0 || vld !== 1'b0) begin
        bad++; $display("FAIL rdw_drain cyc=%0d got rmask=%h v=%b want 0/0", i, imem_rmask, vld);
      end
    end
    @(negedge clk);
    total++; if (imem_rmask !== 4'hF || imem_addr !== 32'h6000_0100) begin bad++; $display("FAIL rdw_req got rmask=%h addr=%h want f/60000100", imem_rmask, imem_addr); end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (vld !== 1'b1 || pkt !== ref_pkt(mem_word(32'h6000_0100), 32'h6000_0100, 64'd0)) begin
      bad++; $display("FAIL rdw_pkt got v=%b pc=%h ord=%0d want v=1 pc=60000100 ord=0", vld, pkt.pc, pkt.order);
    end
  endtask

  task automatic test_redirect_resp();
    do_reset();
    lat = 1;
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h6000_0203;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL rdr_valid got=%b want=0", vld); end
    total++; if (imem_rmask !== 4'hF || imem_addr !== 32'h6000_0200) begin bad++; $display("FAIL rdr_req got rmask=%h addr=%h want f/60000200", imem_rmask, imem_addr); end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (vld !== 1'b1 || pkt !== ref_pkt(mem_word(32'h6000_0200), 32'h6000_0200, 64'd0)) begin
      bad++; $display("FAIL rdr_pkt got v=%b pc=%h ord=%0d want v=1 pc=60000200 ord=0", vld, pkt.pc, pkt.order);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 1;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    total++; if (vld !== 1'b1 || pkt.order !== 64'd2) begin bad++; $display("FAIL rmid_pre got v=%b ord=%0d want 1/2", vld, pkt.order); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (imem_rmask !== 4'h0 || vld !== 1'b0 || pkt.order !== 64'd0) begin
      bad++; $display("FAIL rmid_rst got rmask=%h v=%b ord=%0d want 0/0/0", imem_rmask, vld, pkt.order);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (imem_rmask !== 4'hF || imem_addr !== RST_PC) begin bad++; $display("FAIL rmid_req got rmask=%h addr=%h want f/%h", imem_rmask, imem_addr, RST_PC); end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (vld !== 1'b1 || pkt !== ref_pkt(mem_word(RST_PC), RST_PC, 64'd0)) begin
      bad++; $display("FAIL rmid_pkt got v=%b pc=%h ord=%0d inst=%h want v=1 pc=%h ord=0", vld, pkt.pc, pkt.order, pkt.inst, RST_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0]      exp_pc;
    logic [63:0]      exp_ord;
    logic             prev_vld, prev_stall, prev_redir;
    if_id_stage_reg_t prev_pkt, e;
    int               n_new;
    do_reset();
    exp_pc = RST_PC; exp_ord = '0;
    prev_vld = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0; prev_pkt = '0;
    n_new = 0;
    for (int k = 0; k < 800; k++) begin
      @(posedge clk); #1;
      stall       = ($urandom_range(3) == 0);
      redirect    = ($urandom_range(29) == 0);
      redirect_pc = 32'h6000_0000 + ($urandom_range(255) << 2) + $urandom_range(3);
      lat         = 1 + $urandom_range(2);
      @(negedge clk);
      if (prev_redir) begin
        total++; if (vld !== 1'b0) begin bad++; $display("FAIL rnd_redir_bubble k=%0d got v=%b want 0", k, vld); end
      end else if (prev_vld && prev_stall) begin
        total++;
        if (vld !== 1'b1 || pkt !== prev_pkt) begin
          bad++; $display("FAIL rnd_hold k=%0d got v=%b pc=%h ord=%0d want v=1 pc=%h ord=%0d",
                          k, vld, pkt.pc, pkt.order, prev_pkt.pc, prev_pkt.order);
        end
      end else if (vld === 1'b1) begin
        e = ref_pkt(mem_word(exp_pc), exp_pc, exp_ord);
        total++;
        if (pkt !== e) begin
          bad++; $display("FAIL rnd_pkt k=%0d got pc=%h ord=%0d inst=%h want pc=%h ord=%0d inst=%h",
                          k, pkt.pc, pkt.order, pkt.inst, e.pc, e.order, e.inst);
        end
        exp_pc  = exp_pc + 32'd4;
        exp_ord = exp_ord + 64'd1;
        n_new++;
      end
      prev_vld = vld; prev_stall = stall; prev_redir = redirect; prev_pkt = pkt;
      if (redirect) exp_pc = redirect_pc & ~32'h3;
    end
    @(posedge clk); #1;
    stall = 1'b0; redirect = 1'b0;
    total++; if (n_new < 40) begin bad++; $display("FAIL rnd_progress got=%0d packets want>=40", n_new); end
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_sequential();
    test_decode();
    test_stall();
    test_redirect_wait();
    test_redirect_resp();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
